// File: rtl/spi_ms_sched.sv
// spi_ms_sched: round-robin scheduler that shares one spi_ms master core among
// NREQ byte-transfer requesters. It programs the core SFRs, selects the slave,
// polls SPIF with a timeout, and hands the received byte back to the winner.
module spi_ms_sched #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 4096,
  parameter int GAP     = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] req_mode,
  input  logic [6*NREQ-1:0] req_br,
  input  logic [3*NREQ-1:0] req_ss,
  input  logic [8*NREQ-1:0] req_tx,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [7:0]        rx_data,
  output logic              err,
  output logic              busy,
  output logic [1:0]        sfraddr_w,
  output logic              sfrwe,
  output logic [7:0]        spidata_o,
  output logic [2:0]        sfraddr_r,
  input  logic [7:0]        sfr_data_i,
  output logic [7:0]        spssn_o
);
  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);
  localparam int GW = $clog2(GAP + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CFG0, S_CFG1, S_CFG2, S_LOAD, S_SEL, S_WAIT, S_READ, S_ABORT, S_DESEL
  } state_t;

  // Control register image: SPE and MSTR set, clock mode in bits 3:2.
  function automatic logic [7:0] ctrl_byte(input logic [1:0] mode);
    return {4'b0101, mode, 2'b00};
  endfunction

  // Baud register image: prescale in bits 6:4, divider in bits 2:0.
  function automatic logic [7:0] baud_byte(input logic [5:0] br);
    return {1'b0, br[5:3], 1'b0, br[2:0]};
  endfunction

  state_t          state_r, state_s;
  logic            phase_r, phase_s;
  logic [CW-1:0]   wait_cnt_r, wait_cnt_s;
  logic [GW-1:0]   gap_cnt_r, gap_cnt_s;
  logic [PW-1:0]   ptr_r, ptr_s, idx_r, idx_s;
  logic [1:0]      mode_r, mode_s, cache_mode_r, cache_mode_s;
  logic [5:0]      br_r, br_s, cache_br_r, cache_br_s;
  logic [2:0]      ss_r, ss_s;
  logic [7:0]      tx_r, tx_s;
  logic            cache_valid_r, cache_valid_s;
  logic [NREQ-1:0] gnt_s, done_s;
  logic [7:0]      rx_data_s, spidata_s, spssn_s;
  logic            err_s, busy_s, sfrwe_s;
  logic [1:0]      sfraddr_w_s;
  logic [2:0]      sfraddr_r_s;

  logic [1:0]      mode_a [NREQ];
  logic [5:0]      br_a   [NREQ];
  logic [2:0]      ss_a   [NREQ];
  logic [7:0]      tx_a   [NREQ];
  logic            win_found_s, take_s;
  logic [PW-1:0]   win_idx_s, cand_s;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign mode_a[g] = req_mode[2*g +: 2];
    assign br_a[g]   = req_br[6*g +: 6];
    assign ss_a[g]   = req_ss[3*g +: 3];
    assign tx_a[g]   = req_tx[8*g +: 8];
  end

  // Round-robin pick: first requesting index at or after the pointer, wrapping.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    cand_s      = '0;
    take_s      = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      cand_s      = PW'((int'(ptr_r) + i) % NREQ);
      take_s      = req[cand_s] & ~win_found_s;
      win_idx_s   = take_s ? cand_s : win_idx_s;
      win_found_s = win_found_s | take_s;
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_s       = state_r;
    phase_s       = phase_r;
    wait_cnt_s    = wait_cnt_r;
    gap_cnt_s     = gap_cnt_r;
    ptr_s         = ptr_r;
    idx_s         = idx_r;
    mode_s        = mode_r;
    br_s          = br_r;
    ss_s          = ss_r;
    tx_s          = tx_r;
    cache_valid_s = cache_valid_r;
    cache_mode_s  = cache_mode_r;
    cache_br_s    = cache_br_r;
    gnt_s         = '0;
    done_s        = '0;
    err_s         = 1'b0;
    rx_data_s     = rx_data;
    sfrwe_s       = 1'b0;
    sfraddr_w_s   = sfraddr_w;
    spidata_s     = spidata_o;
    sfraddr_r_s   = 3'b101;
    spssn_s       = spssn_o;
    case (state_r)
      S_IDLE: begin
        if (win_found_s) begin
          gnt_s   = {{(NREQ-1){1'b0}}, 1'b1} << win_idx_s;
          idx_s   = win_idx_s;
          ptr_s   = (win_idx_s == PW'(NREQ - 1)) ? '0 : win_idx_s + 1'b1;
          mode_s  = mode_a[win_idx_s];
          br_s    = br_a[win_idx_s];
          ss_s    = ss_a[win_idx_s];
          tx_s    = tx_a[win_idx_s];
          phase_s = 1'b0;
          sfrwe_s = 1'b1;
          if (cache_valid_r && (cache_mode_r == mode_a[win_idx_s]) &&
              (cache_br_r == br_a[win_idx_s])) begin
            state_s     = S_LOAD;
            sfraddr_w_s = 2'd3;
            spidata_s   = tx_a[win_idx_s];
          end else begin
            state_s     = S_CFG0;
            sfraddr_w_s = 2'd0;
            spidata_s   = ctrl_byte(mode_a[win_idx_s]);
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_CFG0, S_CFG1, S_CFG2, S_LOAD, S_ABORT: begin
        // Each write slot is two cycles; phase 1 selects the next slot.
        if (!phase_r) begin
          phase_s = 1'b1;
          sfrwe_s = 1'b1;
        end else begin
          phase_s = 1'b0;
          case (state_r)
            S_CFG0: begin
              state_s = S_CFG1; sfrwe_s = 1'b1; sfraddr_w_s = 2'd1; spidata_s = 8'h01;
            end
            S_CFG1: begin
              state_s = S_CFG2; sfrwe_s = 1'b1; sfraddr_w_s = 2'd2; spidata_s = baud_byte(br_r);
            end
            S_CFG2: begin
              state_s       = S_LOAD;
              sfrwe_s       = 1'b1;
              sfraddr_w_s   = 2'd3;
              spidata_s     = tx_r;
              cache_valid_s = 1'b1;
              cache_mode_s  = mode_r;
              cache_br_s    = br_r;
            end
            S_LOAD: begin
              state_s = S_SEL;
              spssn_s = ~(8'h01 << ss_r);
            end
            default: begin
              state_s   = S_DESEL;
              rx_data_s = 8'h00;
              err_s     = 1'b1;
              done_s    = {{(NREQ-1){1'b0}}, 1'b1} << idx_r;
              spssn_s   = 8'hff;
              gap_cnt_s = '0;
            end
          endcase
        end
      end
      S_SEL: begin
        state_s    = S_WAIT;
        wait_cnt_s = '0;
      end
      S_WAIT: begin
        if (sfr_data_i[7]) begin
          state_s     = S_READ;
          phase_s     = 1'b0;
          sfraddr_r_s = 3'b011;
        end else if (wait_cnt_r == WAIT_LAST) begin
          state_s       = S_ABORT;
          phase_s       = 1'b0;
          sfrwe_s       = 1'b1;
          sfraddr_w_s   = 2'd0;
          spidata_s     = 8'h00;
          cache_valid_s = 1'b0;
        end else begin
          wait_cnt_s = (wait_cnt_r == {CW{1'b1}}) ? wait_cnt_r : wait_cnt_r + 1'b1;
        end
      end
      S_READ: begin
        // Data register is sampled on the second read cycle.
        if (!phase_r) begin
          phase_s     = 1'b1;
          sfraddr_r_s = 3'b011;
        end else begin
          state_s   = S_DESEL;
          rx_data_s = sfr_data_i;
          done_s    = {{(NREQ-1){1'b0}}, 1'b1} << idx_r;
          spssn_s   = 8'hff;
          gap_cnt_s = '0;
        end
      end
      S_DESEL: begin
        if (gap_cnt_r == GAP_LAST) begin
          state_s = S_IDLE;
        end else begin
          gap_cnt_s = gap_cnt_r + 1'b1;
        end
      end
      default: begin
        state_s = S_IDLE;
        spssn_s = 8'hff;
      end
    endcase
    busy_s = (state_s != S_IDLE);
  end

  // State, captured request, config cache and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= S_IDLE;
      phase_r       <= 1'b0;
      wait_cnt_r    <= '0;
      gap_cnt_r     <= '0;
      ptr_r         <= '0;
      idx_r         <= '0;
      mode_r        <= 2'b00;
      br_r          <= 6'd0;
      ss_r          <= 3'd0;
      tx_r          <= 8'h00;
      cache_valid_r <= 1'b0;
      cache_mode_r  <= 2'b00;
      cache_br_r    <= 6'd0;
      gnt           <= '0;
      done          <= '0;
      rx_data       <= 8'h00;
      err           <= 1'b0;
      busy          <= 1'b0;
      sfrwe         <= 1'b0;
      sfraddr_w     <= 2'd0;
      spidata_o     <= 8'h00;
      sfraddr_r     <= 3'b101;
      spssn_o       <= 8'hff;
    end else begin
      state_r       <= state_s;
      phase_r       <= phase_s;
      wait_cnt_r    <= wait_cnt_s;
      gap_cnt_r     <= gap_cnt_s;
      ptr_r         <= ptr_s;
      idx_r         <= idx_s;
      mode_r        <= mode_s;
      br_r          <= br_s;
      ss_r          <= ss_s;
      tx_r          <= tx_s;
      cache_valid_r <= cache_valid_s;
      cache_mode_r  <= cache_mode_s;
      cache_br_r    <= cache_br_s;
      gnt           <= gnt_s;
      done          <= done_s;
      rx_data       <= rx_data_s;
      err           <= err_s;
      busy          <= busy_s;
      sfrwe         <= sfrwe_s;
      sfraddr_w     <= sfraddr_w_s;
      spidata_o     <= spidata_s;
      sfraddr_r     <= sfraddr_r_s;
      spssn_o       <= spssn_s;
    end
  end
endmodule

// File: tb/tb_spi_ms_sched.sv
// Bench for spi_ms_sched: directed sequence with randomized fields, checked
// against a transaction-level model (round-robin pick, config cache, slot list).
module tb_spi_ms_sched;
  localparam int NREQ = 4;
  localparam int TMO  = 64;
  localparam int GAP  = 10;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [1:0]        mode_a [NREQ];
  logic [5:0]        br_a   [NREQ];
  logic [2:0]        ss_a   [NREQ];
  logic [7:0]        tx_a   [NREQ];
  logic [2*NREQ-1:0] req_mode;
  logic [6*NREQ-1:0] req_br;
  logic [3*NREQ-1:0] req_ss;
  logic [8*NREQ-1:0] req_tx;
  logic [NREQ-1:0]   gnt, done;
  logic [7:0]        rx_data, spidata_o, sfr_data_i, spssn_o;
  logic              err, busy, sfrwe;
  logic [1:0]        sfraddr_w;
  logic [2:0]        sfraddr_r;

  int total = 0;
  int bad   = 0;
  // Transaction-level model state.
  int   ptr_m;
  bit   cv_m;
  logic [7:0] cc_m;

  spi_ms_sched #(.NREQ(NREQ), .TIMEOUT(TMO), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .req(req), .req_mode(req_mode), .req_br(req_br),
    .req_ss(req_ss), .req_tx(req_tx), .gnt(gnt), .done(done), .rx_data(rx_data),
    .err(err), .busy(busy), .sfraddr_w(sfraddr_w), .sfrwe(sfrwe),
    .spidata_o(spidata_o), .sfraddr_r(sfraddr_r), .sfr_data_i(sfr_data_i),
    .spssn_o(spssn_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    req_mode = '0; req_br = '0; req_ss = '0; req_tx = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_mode[2*i +: 2] = mode_a[i];
      req_br[6*i +: 6]   = br_a[i];
      req_ss[3*i +: 3]   = ss_a[i];
      req_tx[8*i +: 8]   = tx_a[i];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] m, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (m[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return 0;
  endfunction

  // One complete transfer: wait for grant, act as the core, compare with the model.
  task automatic run_xfer(input int exp_lat, input int dly, input logic [7:0] echo,
                          input bit drop, output int who);
    int lat, nonff, cyc, sel_first, sel_last, rd_n, rd_first, done_cyc, busy_low;
    int nslot, s, exp_done, bv;
    bit hit, spif, rd_seen;
    logic [7:0] cfg, ssv, done_v, rx_v, d_l [4];
    logic [1:0] a_l [4];
    logic err_v;
    logic [31:0] obs_q [$];
    logic [31:0] exp_q [$];

    who = rr_pick(req, ptr_m);
    lat = 0; nonff = 0;
    do begin
      @(negedge clk); lat++;
      if (spssn_o !== 8'hff) nonff++;
    end while (gnt === '0 && lat < 60);
    chk("gnt_latency", lat, exp_lat);
    chk("gap_ssn_high", nonff, 0);
    chk("gnt_onehot", gnt, 32'd1 << who);
    ptr_m = (who + 1) % NREQ;
    cfg   = {mode_a[who], br_a[who]};
    hit   = cv_m && (cc_m == cfg);
    if (drop) req[who] = 1'b0;

    sel_first = -1; sel_last = -1; rd_n = 0; rd_first = -1; done_cyc = -1;
    busy_low = 0; spif = 0; rd_seen = 0; ssv = 8'hff; done_v = 0; rx_v = 0; err_v = 0;
    for (cyc = 0; cyc < TMO + 60; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (sfrwe === 1'b1) obs_q.push_back({16'(cyc), 6'd0, sfraddr_w, spidata_o});
      if (spssn_o !== 8'hff) begin
        if (sel_first < 0) begin sel_first = cyc; ssv = spssn_o; end
        sel_last = cyc;
      end
      if (sfraddr_r === 3'b011) begin
        rd_n++; rd_seen = 1; spif = 0;
        if (rd_first < 0) rd_first = cyc;
      end
      if (busy !== 1'b1) busy_low++;
      if (done !== '0) begin
        done_cyc = cyc; done_v = 8'(done); err_v = err; rx_v = rx_data;
        break;
      end
      if (sel_first >= 0 && dly >= 0 && !rd_seen && cyc >= sel_first + 1 + dly) spif = 1;
      sfr_data_i = (sfraddr_r === 3'b011) ? echo : {spif, 7'($urandom)};
    end
    sfr_data_i = 8'h00;

    // Expected slot list from the request fields.
    bv = br_a[who];
    a_l[0] = 2'd0; d_l[0] = 8'h50 + 8'(mode_a[who]) * 8'd4;
    a_l[1] = 2'd1; d_l[1] = 8'h01;
    a_l[2] = 2'd2; d_l[2] = 8'((bv / 8) * 16 + bv % 8);
    a_l[3] = 2'd3; d_l[3] = tx_a[who];
    nslot = hit ? 1 : 4;
    for (int k = 0; k < nslot; k++) begin
      for (int h = 0; h < 2; h++) begin
        exp_q.push_back({16'(2*k + h), 6'd0, a_l[4 - nslot + k], d_l[4 - nslot + k]});
      end
    end
    s = 2 * nslot;
    if (dly < 0) begin
      exp_q.push_back({16'(s + TMO + 1), 6'd0, 2'd0, 8'h00});
      exp_q.push_back({16'(s + TMO + 2), 6'd0, 2'd0, 8'h00});
      exp_done = s + TMO + 3;
      cv_m = 0;
    end else begin
      exp_done = s + 4 + dly;
      cv_m = 1; cc_m = cfg;
    end

    chk("write_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) chk("write_slot", obs_q[i], exp_q[i]);
    chk("sel_start", sel_first, s);
    chk("sel_value", ssv, 8'hff ^ (8'd1 << ss_a[who]));
    chk("sel_end", sel_last, exp_done - 1);
    chk("read_cycles", rd_n, (dly < 0) ? 0 : 2);
    if (dly >= 0) chk("read_start", rd_first, s + 2 + dly);
    chk("done_cycle", done_cyc, exp_done);
    chk("done_onehot", done_v, 32'd1 << who);
    chk("err", err_v, (dly < 0) ? 1 : 0);
    chk("rx_data", rx_v, (dly < 0) ? 8'h00 : echo);
    chk("busy_during", busy_low, 0);
  endtask

  initial begin
    int who, nd, s, msk;
    bit hit;
    rst = 1'b1; req = '0; sfr_data_i = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      mode_a[i] = 2'd0; br_a[i] = 6'd0; ss_a[i] = 3'd0; tx_a[i] = 8'h00;
    end
    ptr_m = 0; cv_m = 0; cc_m = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_gnt", gnt, 0);        chk("rst_done", done, 0);
    chk("rst_err", err, 0);        chk("rst_busy", busy, 0);
    chk("rst_rx", rx_data, 0);     chk("rst_sfrwe", sfrwe, 0);
    chk("rst_waddr", sfraddr_w, 0); chk("rst_wdata", spidata_o, 0);
    chk("rst_raddr", sfraddr_r, 3'b101); chk("rst_ssn", spssn_o, 8'hff);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single request, then an identical repeat (cache hit), then a timeout.
    mode_a[0] = 2'b00; br_a[0] = 6'o03; ss_a[0] = 3'd0; tx_a[0] = 8'hA5;
    req[0] = 1'b1; run_xfer(1, 2, 8'h3C, 1'b1, who);
    req[0] = 1'b1; run_xfer(GAP + 1, 0, 8'h5A, 1'b1, who);
    req[0] = 1'b1; run_xfer(GAP + 1, -1, 8'h77, 1'b1, who);
    req[0] = 1'b1; run_xfer(GAP + 1, 1, 8'hC3, 1'b1, who);

    // Reset while requester 2 waits for SPIF.
    mode_a[2] = 2'b10; br_a[2] = 6'o21; ss_a[2] = 3'd5; tx_a[2] = 8'h42;
    req[2] = 1'b1;
    who = rr_pick(req, ptr_m);
    hit = cv_m && (cc_m == {mode_a[2], br_a[2]});
    nd = 0;
    do begin @(negedge clk); nd++; end while (gnt === '0 && nd < 60);
    chk("rst_case_gnt", gnt, 32'd1 << who);
    req[2] = 1'b0;
    s = hit ? 2 : 8;
    repeat (s + 3) @(negedge clk);
    chk("rst_case_sel", spssn_o, 8'hdf);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_case_ssn", spssn_o, 8'hff);
    chk("rst_case_busy", busy, 0);
    chk("rst_case_we", sfrwe, 0);
    rst = 1'b0; ptr_m = 0; cv_m = 0;
    nd = 0;
    repeat (TMO + 20) begin
      @(negedge clk);
      if (done !== '0) nd++;
    end
    chk("rst_case_no_done", nd, 0);

    // All four requesting: strict rotation from pointer 0, every one a miss.
    for (int i = 0; i < NREQ; i++) begin
      mode_a[i] = 2'(i); br_a[i] = 6'o03; ss_a[i] = 3'($urandom); tx_a[i] = 8'($urandom);
    end
    req = '1;
    for (int k = 0; k < 5; k++) begin
      run_xfer((k == 0) ? 1 : GAP + 1, int'($urandom_range(0, 3)), 8'($urandom), 1'b0, who);
      chk("rotation_order", who, k % NREQ);
    end
    req = '0;

    // Sweep every baud code and slave index on requester 1.
    for (int b = 0; b < 64; b++) begin
      br_a[1] = 6'(b); ss_a[1] = 3'(b % 8); mode_a[1] = 2'($urandom); tx_a[1] = 8'($urandom);
      req[1] = 1'b1;
      run_xfer(GAP + 1, int'($urandom_range(0, 3)), 8'($urandom), 1'b1, who);
    end

    // Random mixes of requesters drawn from a small config pool.
    for (int k = 0; k < 16; k++) begin
      msk = int'($urandom_range(1, 15));
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && msk[i]) begin
          mode_a[i] = 2'($urandom_range(0, 1)); br_a[i] = ($urandom_range(0, 1) != 0) ? 6'o03 : 6'o15;
          ss_a[i] = 3'($urandom); tx_a[i] = 8'($urandom); req[i] = 1'b1;
        end
      end
      run_xfer(GAP + 1, ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 4)),
               8'($urandom), 1'b1, who);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
